// File: rtl/qdec_pkg.sv
// Shared constants and transition decode for the quadrature decoder.
package qdec_pkg;

  // Phase-pair encoding {A,B}; listed in up-count (A leads B) order.
  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    StepNone,
    StepUp,
    StepDown,
    StepIllegal
  } step_e;

  // True when cur is the next state after prev in the up sequence.
  function automatic logic qdec_is_up(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev == QS_00) && (cur == QS_10)) ||
           ((prev == QS_10) && (cur == QS_11)) ||
           ((prev == QS_11) && (cur == QS_01)) ||
           ((prev == QS_01) && (cur == QS_00));
  endfunction

  // True when cur is the next state after prev in the down sequence.
  function automatic logic qdec_is_down(input logic [1:0] prev, input logic [1:0] cur);
    return qdec_is_up(cur, prev);
  endfunction

  // Classify one sampled transition; both bits changing is illegal.
  function automatic step_e qdec_decode(input logic [1:0] prev, input logic [1:0] cur);
    if (qdec_is_up(prev, cur)) begin
      return StepUp;
    end else if (qdec_is_down(prev, cur)) begin
      return StepDown;
    end else if (prev == cur) begin
      return StepNone;
    end
    return StepIllegal;
  endfunction

endpackage

// File: rtl/qdec_sync.sv
// Single-phase input conditioning: SYNC_STAGES-deep synchronizer, optionally followed
// by a stability filter when QDEC_GLITCH_FILTER_EN is defined.
module qdec_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic d_out
);

  // Elaboration-time legality checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("qdec_sync: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 2) begin : g_bad_filter_len
    $error("qdec_sync: FILTER_LEN must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int unsigned CntW = $clog2(FILTER_LEN);

  logic            filt_q;
  logic [CntW-1:0] stab_cnt_q;

  // Accept a new level only after it has differed from the output for FILTER_LEN cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q     <= 1'b0;
      stab_cnt_q <= '0;
    end else if (sync_out == filt_q) begin
      stab_cnt_q <= '0;
    end else if (stab_cnt_q == CntW'(FILTER_LEN - 1)) begin
      filt_q     <= sync_out;
      stab_cnt_q <= '0;
    end else begin
      stab_cnt_q <= stab_cnt_q + CntW'(1);
    end
  end

  assign d_out = filt_q;
`else
  assign d_out = sync_out;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: registered step pulses, wrapping position count and a sticky
// illegal-transition flag. Optional input glitch filter: QDEC_GLITCH_FILTER_EN.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic             step_valid,
  output logic             step_dir,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             err
);

  // Synchronized state only reflects the pins once the reset zeros have drained out of
  // the input path, so priming waits that long before arming the decoder.
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int unsigned PrimeLen = SYNC_STAGES + FILTER_LEN;
`else
  localparam int unsigned PrimeLen = SYNC_STAGES;
`endif
  localparam int unsigned PcW = $clog2(PrimeLen + 1);

  logic             a_sync, b_sync;
  logic [1:0]       s;
  logic [1:0]       prev_q;
  logic [PcW-1:0]   prime_cnt_q;
  logic             primed_q;
  step_e            step_kind;
  logic             step_up, step_dn;
  logic             step_valid_q, step_dir_q, wrap_q, err_q;
  logic             step_valid_d, step_dir_d, wrap_d, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  qdec_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_a (
    .clk  (clk),
    .reset(reset),
    .d_in (a_in),
    .d_out(a_sync)
  );

  qdec_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_b (
    .clk  (clk),
    .reset(reset),
    .d_in (b_in),
    .d_out(b_sync)
  );

  assign s = {a_sync, b_sync};

  // Count cycles after reset release until the synchronized state is trustworthy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else if (!primed_q) begin
      if (prime_cnt_q == PcW'(PrimeLen)) begin
        primed_q <= 1'b1;
      end else begin
        prime_cnt_q <= prime_cnt_q + PcW'(1);
      end
    end
  end

  // Classify the transition and form next-state values for count and flags.
  always_comb begin
    step_kind = StepNone;
    if (primed_q) begin
      step_kind = qdec_decode(prev_q, s);
    end
    step_up      = (step_kind == StepUp);
    step_dn      = (step_kind == StepDown);
    step_valid_d = step_up | step_dn;
    step_dir_d   = step_up ? DIR_UP : DIR_DOWN;

    wrap_d  = 1'b0;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      // Clear wins over a coincident step; the step is still reported.
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (step_up) begin
        count_d = count_q + CNT_W'(1);
        wrap_d  = (count_q == {CNT_W{1'b1}});
      end else if (step_dn) begin
        count_d = count_q - CNT_W'(1);
        wrap_d  = (count_q == '0);
      end
      if (step_kind == StepIllegal) begin
        err_d = 1'b1;
      end
    end
  end

  // Register decoded outputs; prev_q tracks the synchronized state every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= QS_00;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      wrap_q       <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      prev_q       <= s;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      wrap_q       <= wrap_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign wrap       = wrap_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a random walk, all
// checked cycle by cycle against a position model built on Gray-code index arithmetic.
module tb_quad_decoder;

  localparam int CNT_W = 4;
  localparam int SYNC  = 2;
  localparam int FLEN  = 3;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT     = SYNC + FLEN;
  localparam int MINHOLD = FLEN;
`else
  localparam int LAT     = SYNC;
  localparam int MINHOLD = 1;
`endif
  localparam int MAXC = 4096;
  localparam int MAXV = (1 << CNT_W) - 1;

  logic             clk, reset, a_in, b_in, clear;
  logic             step_valid, step_dir, wrap, err;
  logic [CNT_W-1:0] count;

  quad_decoder #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .FILTER_LEN (FLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .clear     (clear),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .count     (count),
    .wrap      (wrap),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ev[n]: transition whose outputs appear after edge n (0 none, 1 up, 2 down, 3 illegal).
  int         ev[MAXC];
  bit         clr_at[MAXC];
  int         cyc, total, bad;
  int         pos;
  bit         m_err;
  logic [1:0] cur;
  int         steps_seen, wraps_seen, ups_seen;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Position of a phase pair along the up sequence 00,10,11,01.
  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gstate(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int classify(input logic [1:0] p, input logic [1:0] n);
    int d;
    d = (gidx(n) - gidx(p) + 4) % 4;
    if (d == 0) return 0;
    if (d == 1) return 1;
    if (d == 3) return 2;
    return 3;
  endfunction

  // Compare DUT outputs after edge cyc with the model.
  task automatic observe();
    int  k;
    bit  c, exp_valid, exp_wrap;
    if (reset) begin
      check("rst_valid", step_valid, 0);
      check("rst_dir", step_dir, 0);
      check("rst_count", count, 0);
      check("rst_wrap", wrap, 0);
      check("rst_err", err, 0);
      return;
    end
    k = ev[cyc];
    c = clr_at[cyc];
    exp_valid = (k == 1) || (k == 2);
    exp_wrap  = !c && (((k == 1) && (pos == MAXV)) || ((k == 2) && (pos == 0)));
    if (c) pos = 0;
    else if (k == 1) pos = (pos + 1) % (MAXV + 1);
    else if (k == 2) pos = (pos + MAXV) % (MAXV + 1);
    if (c) m_err = 0;
    else if (k == 3) m_err = 1;
    check("valid", step_valid, exp_valid);
    if (exp_valid) check("dir", step_dir, (k == 1));
    check("count", count, pos);
    check("wrap", wrap, exp_wrap);
    check("err", err, m_err);
    if (step_valid) steps_seen++;
    if (step_valid && step_dir) ups_seen++;
    if (wrap) wraps_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    observe();
  endtask

  task automatic drive(input logic [1:0] s, input int hold);
    int k;
    k = cyc + 1 + LAT;
    if (s != cur && k < MAXC) ev[k] = classify(cur, s);
    cur  = s;
    a_in = s[1];
    b_in = s[0];
    repeat (hold) tick();
  endtask

  task automatic step(input bit up, input int hold);
    drive(gstate(gidx(cur) + (up ? 1 : 3)), hold);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    if (cyc + 1 < MAXC) clr_at[cyc + 1] = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 2) tick();
  endtask

  int s0, w0, u0, r;

  initial begin
    cyc = 0; total = 0; bad = 0; pos = 0; m_err = 0;
    steps_seen = 0; wraps_seen = 0; ups_seen = 0;
    for (int i = 0; i < MAXC; i++) begin
      ev[i] = 0;
      clr_at[i] = 1'b0;
    end
    reset = 1'b1; clear = 1'b0; a_in = 1'b1; b_in = 1'b1; cur = 2'b11;

    // 1: priming with encoder resting at 11.
    repeat (3) tick();
    reset = 1'b0;
    repeat (12) tick();
    check("t1_steps", steps_seen, 0);
    check("t1_count", count, 0);
    check("t1_err", err, 0);

    // Walk to 00 and clear so the next test starts at count 0.
    drive(2'b01, 5);
    drive(2'b00, 5);
    settle();
    check("t1_walk_count", count, 2);
    pulse_clear();
    settle();

    // 2: sixteen up steps from 00.
    s0 = steps_seen; w0 = wraps_seen; u0 = ups_seen;
    for (int i = 0; i < 16; i++) step(1'b1, 5);
    settle();
    check("t2_steps", steps_seen - s0, 16);
    check("t2_ups", ups_seen - u0, 16);
    check("t2_wraps", wraps_seen - w0, 1);
    check("t2_count", count, 0);

    // 3: wrap in both directions.
    w0 = wraps_seen;
    step(1'b0, 5);
    settle();
    check("t3_down_count", count, MAXV);
    step(1'b1, 5);
    settle();
    check("t3_up_count", count, 0);
    check("t3_wraps", wraps_seen - w0, 2);

    // 4: illegal jump at count 5 from 00.
    for (int i = 0; i < 3; i++) step(1'b1, 5);
    pulse_clear();
    for (int i = 0; i < 5; i++) step(1'b1, 5);
    settle();
    check("t4_pre_count", count, 5);
    check("t4_pre_state", cur, 0);
    s0 = steps_seen;
    drive(2'b11, 6);
    settle();
    check("t4_ill_steps", steps_seen - s0, 0);
    check("t4_ill_count", count, 5);
    check("t4_ill_err", err, 1);
    step(1'b1, 5);
    settle();
    check("t4_next_count", count, 6);
    check("t4_next_err", err, 1);
    pulse_clear();
    tick();
    check("t4_clr_count", count, 0);
    check("t4_clr_err", err, 0);

    // 5: clear coincident with a step decoded at count 7.
    for (int i = 0; i < 7; i++) step(1'b1, 5);
    settle();
    check("t5_pre_count", count, 7);
    drive(gstate(gidx(cur) + 1), 1);
    repeat (LAT - 1) tick();
    pulse_clear();
    check("t5_valid", step_valid, 1);
    check("t5_count", count, 0);
    check("t5_wrap", wrap, 0);
    settle();

`ifdef QDEC_GLITCH_FILTER_EN
    // 6: short pulse rejected, stable change accepted.
    s0 = steps_seen;
    a_in = ~cur[1];
    repeat (FLEN - 1) tick();
    a_in = cur[1];
    repeat (10) tick();
    check("t6_glitch_steps", steps_seen - s0, 0);
    step(1'b1, 10);
    check("t6_good_steps", steps_seen - s0, 1);
`endif

    // Random walk with occasional illegal jumps and clears.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) drive(cur ^ 2'b11, $urandom_range(MINHOLD, MINHOLD + 4));
      else if (r == 1) pulse_clear();
      else step(r < 9, $urandom_range(MINHOLD, MINHOLD + 4));
    end
    settle();

    // Reset mid-operation: outputs drop without waiting for an edge.
    pulse_clear();
    step(1'b1, 5);
    step(1'b1, LAT + 1);
    step(1'b1, 1);
    check("mr_pre_count", count, 2);
    #2;
    reset = 1'b1;
    #1;
    check("mr_valid", step_valid, 0);
    check("mr_count", count, 0);
    check("mr_wrap", wrap, 0);
    check("mr_err", err, 0);
    pos = 0;
    m_err = 0;
    for (int i = cyc; i < MAXC; i++) begin
      ev[i] = 0;
      clr_at[i] = 1'b0;
    end
    repeat (3) tick();
    reset = 1'b0;
    s0 = steps_seen;
    repeat (12) tick();
    check("mr_reprime_steps", steps_seen - s0, 0);
    step(1'b0, 5);
    settle();
    check("mr_after_count", count, MAXV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
